// File: rtl/muldiv_controller.sv
// -----------------------------------------------------------------------------
// muldiv_controller
//   Iterative 32x32 multiply / divide unit for a MIPS-style pipeline. An
//   operation is accepted on one edge (cycle 0). It then runs one radix-2 step
//   per cycle on operand magnitudes for 32 cycles (RUN). One sign-fixup cycle
//   follows (FIX). HI/LO are written as the unit enters DONE, where Done pulses
//   for one cycle. Division by zero bypasses RUN/FIX and reaches DONE at
//   cycle 1.
//
//   Build option: define MULDIV_EARLY_OUT_EN to let a multiply leave RUN as
//   soon as the remaining multiplier magnitude is zero. Divide is unaffected.
//
// Ports
//   Clock      in   rising-edge clock
//   Reset      in   synchronous active-high reset
//   Start      in   begin operation Op on OpA/OpB (honoured in IDLE/DONE only)
//   Op[1:0]    in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   OpA, OpB   in   32-bit source operands (rs, rt)
//   Flush      in   squash the in-flight operation (wins over Start)
//   HiLoRead   in   ID-stage instruction is MFHI/MFLO
//   Stall      out  HiLoRead while busy: freeze PC and IF/ID
//   Busy       out  operation in RUN or FIX
//   Done       out  one-cycle completion pulse
//   HI, LO     out  result registers
//   DivByZero  out  set for the DONE cycle of a divide by zero
// -----------------------------------------------------------------------------
module muldiv_controller (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  input  logic        Flush,
  input  logic        HiLoRead,
  output logic        Stall,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        DivByZero
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic        is_div_q;
  logic        sign_a_q;       // OpA negative and the operation is signed
  logic        sign_b_q;       // OpB negative and the operation is signed
  // opa_q: |A|; in a divide it doubles as the dividend/quotient shift register.
  // opb_q: |B|; in a multiply it doubles as the shifting multiplier.
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  // acc_q: product accumulator; its upper half is the partial remainder.
  logic [63:0] acc_q;
  logic [63:0] mcand_q;        // multiplicand, shifted left one place per step
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
  logic        dbz_q;

  // ---------------------------------------------------------------------------
  // Accept-time operand magnitudes
  // ---------------------------------------------------------------------------
  logic        in_sign_a;
  logic        in_sign_b;
  logic [31:0] in_mag_a;
  logic [31:0] in_mag_b;

  // NOTE: every signal in an always_comb is assigned on every path, so no
  // latch can be inferred.
  always_comb begin
    in_sign_a = ~Op[0] & OpA[31];
    in_sign_b = ~Op[0] & OpB[31];
    // The magnitude of 32'h80000000 is 2^31, which is still exact as unsigned.
    in_mag_a  = in_sign_a ? (~OpA + 32'd1) : OpA;
    in_mag_b  = in_sign_b ? (~OpB + 32'd1) : OpB;
  end

  // ---------------------------------------------------------------------------
  // One radix-2 step
  // ---------------------------------------------------------------------------
  logic [63:0] mul_acc_d;
  logic [31:0] mul_mplier_d;
  logic [32:0] div_partial;
  logic [32:0] div_trial;
  logic        div_ge;
  logic [31:0] div_rem_d;
  logic [31:0] div_quo_d;

  always_comb begin
    // Shift-add: add the multiplicand when the multiplier LSB is set.
    mul_acc_d    = opb_q[0] ? (acc_q + mcand_q) : acc_q;
    mul_mplier_d = {1'b0, opb_q[31:1]};
    // Restoring divide: bring in the next dividend bit, then trial-subtract.
    // The partial remainder stays below the divisor, so the trial result fits
    // in 32 bits when it is non-negative. Bit 32 is the borrow.
    div_partial  = {acc_q[63:32], opa_q[31]};
    div_trial    = div_partial - {1'b0, opb_q};
    div_ge       = ~div_trial[32];
    div_rem_d    = div_ge ? div_trial[31:0] : div_partial[31:0];
    div_quo_d    = {opa_q[30:0], div_ge};
  end

  logic early_out;
`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = ~is_div_q & (mul_mplier_d == 32'd0);
`else
  assign early_out = 1'b0;
`endif

  logic last_step;
  assign last_step = (cnt_q == 6'd31) | early_out;

  // ---------------------------------------------------------------------------
  // Sign fixup applied in FIX
  // ---------------------------------------------------------------------------
  logic        fix_neg;
  logic [63:0] fix_prod;
  logic [31:0] fix_quo;
  logic [31:0] fix_rem;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  always_comb begin
    fix_neg  = sign_a_q ^ sign_b_q;
    fix_prod = fix_neg ? (~acc_q + 64'd1) : acc_q;
    fix_quo  = fix_neg ? (~opa_q + 32'd1) : opa_q;
    // The remainder takes the sign of the dividend.
    fix_rem  = sign_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    fix_hi   = is_div_q ? fix_rem : fix_prod[63:32];
    fix_lo   = is_div_q ? fix_quo : fix_prod[31:0];
  end

  // ---------------------------------------------------------------------------
  // Controller and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // update together from the values present before the edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      // NOTE: the working registers are cleared too. An aborted operation then
      // leaves no stale operands behind.
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          // A squashed instruction must not start an operation.
          if (Start && !Flush) begin
            cnt_q    <= '0;
            is_div_q <= Op[1];
            sign_a_q <= in_sign_a;
            sign_b_q <= in_sign_b;
            opa_q    <= in_mag_a;
            opb_q    <= in_mag_b;
            acc_q    <= '0;
            mcand_q  <= {32'd0, in_mag_a};
            if (Op[1] && (OpB == 32'd0)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
              hi_q    <= OpA;
              lo_q    <= '1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (Flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 6'd1;
            if (is_div_q) begin
              acc_q[63:32] <= div_rem_d;
              opa_q        <= div_quo_d;
            end else begin
              acc_q   <= mul_acc_d;
              mcand_q <= {mcand_q[62:0], 1'b0};
              opb_q   <= mul_mplier_d;
            end
            if (last_step) state_q <= FIX;
          end
        end

        FIX: begin
          busy_q <= 1'b0;
          if (Flush) begin
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
            hi_q    <= fix_hi;
            lo_q    <= fix_lo;
          end
        end
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign Stall     = HiLoRead & busy_q;

endmodule

// File: tb/tb_muldiv_controller.sv
// -----------------------------------------------------------------------------
// tb_muldiv_controller
//   Self-checking bench for muldiv_controller. It applies a table of directed
//   vectors, then hand-written multi-cycle sequences: reset, stall, flush,
//   reset abort, ignored Start, DONE->RUN and Flush/Start priority. It finishes
//   with random operations checked against an arithmetic reference model.
//   Cycle n means the n-th clock period after the accepting edge.
// -----------------------------------------------------------------------------
module tb_muldiv_controller;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic        Flush;
  logic        HiLoRead;
  logic        Stall;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        DivByZero;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  muldiv_controller dut (
    .Clock     (clk),
    .Reset     (Reset),
    .Start     (Start),
    .Op        (Op),
    .OpA       (OpA),
    .OpB       (OpB),
    .Flush     (Flush),
    .HiLoRead  (HiLoRead),
    .Stall     (Stall),
    .Busy      (Busy),
    .Done      (Done),
    .HI        (HI),
    .LO        (LO),
    .DivByZero (DivByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural meaning.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dbz, output int cyc);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    cyc = 34;
    if (op[1] == 1'b0) begin
      if (op == 2'b00) p = 64'(sa * sb);
      else             p = {32'd0, a} * {32'd0, b};
      hi = p[63:32];
      lo = p[31:0];
`ifdef MULDIV_EARLY_OUT_EN
      begin
        logic [31:0] m;
        int          n;
        m = (op == 2'b00 && b[31]) ? 32'(-sb) : b;
        n = 0;
        while (m != 0) begin
          n++;
          m = m >> 1;
        end
        cyc = ((n == 0) ? 1 : n) + 2;
      end
`endif
    end else if (b == 32'd0) begin
      hi  = a;
      lo  = '1;
      dbz = 1'b1;
      cyc = 1;
    end else if (op == 2'b10) begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  // Polls Done at negedges starting at cycle 'from' (current point), bounded.
  task automatic wait_done(input int from, output int got);
    got = -1;
    for (int c = from; c <= from + 45; c++) begin
      if (c > from) @(negedge clk);
      if (Done === 1'b1) begin
        got = c;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed,
                        input int ec, input string nm);
    int got;
    int busy_bad;
    got      = -1;
    busy_bad = 0;
    @(negedge clk);
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    @(negedge clk);
    Start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (c > 1) @(negedge clk);
      if (Done === 1'b1) begin
        got = c;
        break;
      end
      if (Busy !== 1'b1) busy_bad++;
    end
    check({nm, ".done_cycle"}, 64'(got), 64'(ec));
    check({nm, ".busy_run"}, 64'(busy_bad), 64'd0);
    check({nm, ".hi"}, {32'd0, HI}, {32'd0, eh});
    check({nm, ".lo"}, {32'd0, LO}, {32'd0, el});
    check({nm, ".dbz"}, {63'd0, DivByZero}, {63'd0, ed});
    check({nm, ".busy_done"}, {63'd0, Busy}, 64'd0);
    @(negedge clk);
    check({nm, ".pulse_end"}, {62'd0, Done, DivByZero}, 64'd0);
    last_hi = eh;
    last_lo = el;
  endtask

  // Starts a long MULTU and aborts it at cycle acyc by Flush or Reset.
  task automatic abort_test(input int acyc, input bit by_reset, input string nm);
    int          seen;
    logic [31:0] eh, el;
    @(negedge clk);
    Start = 1'b1; Op = 2'b01; OpA = 32'hDEADBEEF; OpB = 32'h80000000;
    @(negedge clk);
    Start = 1'b0;
    repeat (acyc - 1) @(negedge clk);
    check({nm, ".busy_before"}, {63'd0, Busy}, 64'd1);
    if (by_reset) Reset = 1'b1;
    else          Flush = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    Flush = 1'b0;
    check({nm, ".busy_after"}, {63'd0, Busy}, 64'd0);
    seen = 0;
    repeat (40) begin
      if (Done === 1'b1) seen++;
      @(negedge clk);
    end
    check({nm, ".no_done"}, 64'(seen), 64'd0);
    eh = by_reset ? 32'd0 : last_hi;
    el = by_reset ? 32'd0 : last_lo;
    check({nm, ".hi"}, {32'd0, HI}, {32'd0, eh});
    check({nm, ".lo"}, {32'd0, LO}, {32'd0, el});
    last_hi = eh;
    last_lo = el;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int          got;
    int          bad;
    logic [1:0]  rop;
    logic [31:0] ra, rb, reh, rel;
    logic        red;
    int          rec;
    int          sel;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0, EARLY ? 4 : 34};
    vecs[1]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[2]  = '{2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1};
    vecs[3]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
    vecs[4]  = '{2'b01, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, EARLY ? 5 : 34};
    vecs[5]  = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, EARLY ? 5 : 34};
    vecs[6]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34};
    vecs[7]  = '{2'b11, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 1'b0, 34};
    vecs[8]  = '{2'b10, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 1};
    vecs[9]  = '{2'b00, 32'd1234,     32'd0,        32'd0,        32'd0,        1'b0, EARLY ? 3 : 34};
    vecs[10] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 34};

    // Reset: outputs low during and after reset; Stall stays low even with HiLoRead.
    Reset = 1'b1; Start = 1'b0; Op = 2'b00; OpA = '0; OpB = '0; Flush = 1'b0; HiLoRead = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.busy", {63'd0, Busy}, 64'd0);
    check("rst.done", {63'd0, Done}, 64'd0);
    check("rst.stall", {63'd0, Stall}, 64'd0);
    check("rst.dbz", {63'd0, DivByZero}, 64'd0);
    check("rst.hilo", {HI, LO}, 64'd0);
    Reset = 1'b0;
    @(negedge clk);
    check("post_rst.stall", {63'd0, Stall}, 64'd0);
    check("post_rst.busy", {63'd0, Busy}, 64'd0);
    HiLoRead = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 11; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz,
             vecs[i].cyc, $sformatf("vec%0d", i));

    // Stall follows HiLoRead only while busy: cycles 1..33 high, cycle 34 low.
    HiLoRead = 1'b1;
    @(negedge clk);
    check("stall.idle", {63'd0, Stall}, 64'd0);
    Start = 1'b1; Op = 2'b01; OpA = 32'h12345678; OpB = 32'h80000001;
    @(negedge clk);
    Start = 1'b0;
    bad = 0;
    for (int c = 1; c <= 34; c++) begin
      if (c > 1) @(negedge clk);
      if (Stall !== (c <= 33)) bad++;
      if (c == 1)  check("stall.c1", {63'd0, Stall}, 64'd1);
      if (c == 33) check("stall.c33", {63'd0, Stall}, 64'd1);
      if (c == 34) begin
        check("stall.c34", {63'd0, Stall}, 64'd0);
        check("stall.done34", {63'd0, Done}, 64'd1);
      end
    end
    check("stall.profile", 64'(bad), 64'd0);
    last_hi = HI;
    last_lo = LO;
    check("stall.result", {HI, LO}, 64'h12345678 * 64'h80000001);
    HiLoRead = 1'b0;
    @(negedge clk);

    // Flush in RUN (cycle 10) and in FIX (cycle 33); Reset mid-RUN.
    abort_test(10, 1'b0, "flush_run");
    abort_test(33, 1'b0, "flush_fix");
    abort_test(15, 1'b1, "reset_run");

    // Start in RUN is ignored and does not disturb the operands.
    @(negedge clk);
    Start = 1'b1; Op = 2'b01; OpA = 32'd1000; OpB = 32'd1000;
    @(negedge clk);
    Start = 1'b0;
    repeat (4) @(negedge clk);
    Start = 1'b1; Op = 2'b11; OpA = 32'd1; OpB = 32'd0;
    @(negedge clk);
    Start = 1'b0;
    wait_done(6, got);
    check("ign_start.cycle", 64'(got), EARLY ? 64'd12 : 64'd34);
    check("ign_start.lo", {32'd0, LO}, 64'd1000000);
    check("ign_start.hi", {32'd0, HI}, 64'd0);
    check("ign_start.dbz", {63'd0, DivByZero}, 64'd0);
    @(negedge clk);

    // Start in DONE goes straight back to RUN.
    Start = 1'b1; Op = 2'b11; OpA = 32'd100; OpB = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    wait_done(1, got);
    check("done_run.first_cycle", 64'(got), 64'd34);
    check("done_run.first_hilo", {HI, LO}, {32'd2, 32'd14});
    Start = 1'b1; Op = 2'b01; OpA = 32'd6; OpB = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    check("done_run.busy", {63'd0, Busy}, 64'd1);
    wait_done(1, got);
    check("done_run.second_cycle", 64'(got), EARLY ? 64'd5 : 64'd34);
    check("done_run.second_hilo", {HI, LO}, {32'd0, 32'd42});
    last_hi = 32'd0;
    last_lo = 32'd42;
    @(negedge clk);

    // Flush together with Start in IDLE: Flush wins, nothing starts.
    Start = 1'b1; Flush = 1'b1; Op = 2'b11; OpA = 32'd9; OpB = 32'd0;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    check("flush_start.busy", {63'd0, Busy}, 64'd0);
    check("flush_start.done", {63'd0, Done}, 64'd0);
    check("flush_start.hilo", {HI, LO}, {last_hi, last_lo});

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'(0 - $urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      model(rop, ra, rb, reh, rel, red, rec);
      run_op(rop, ra, rb, reh, rel, red, rec, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_controller.md
MULDIV_CONTROLLER -- requirements
Module: muldiv_controller

Interface
REQ-001 SHALL have port Clock, input, 1, the single rising-edge clock for all state.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset sampled on rising Clock.
REQ-003 SHALL have port Start, input, 1, request to begin the operation given by Op on OpA/OpB.
REQ-004 SHALL have port Op, input, 2, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports OpA and OpB, input, 32 each, source operands (rs, rt) from the ID-stage forwarding muxes.
REQ-006 SHALL have port Flush, input, 1, abort of the in-flight operation (branch/jump squash).
REQ-007 SHALL have port HiLoRead, input, 1, asserted when the ID instruction is MFHI/MFLO.
REQ-008 SHALL have port Stall, output, 1, freeze request routed to PC_WriteEnable/IFIDWriteEnable.
REQ-009 SHALL have ports Busy and Done, output, 1 each; HI and LO, output, 32 each; DivByZero, output, 1.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-011 SHALL accept Start only in IDLE or DONE; Start in RUN/FIX is ignored and does not alter operands.
REQ-012 SHALL latch OpA, OpB, Op on the accepting edge (cycle 0) and clear the 6-bit iteration counter.
REQ-013 SHALL spend cycles 1..32 in RUN, one radix-2 step per cycle: shift-add multiply, restoring divide, both on operand magnitudes.
REQ-014 SHALL enter FIX at cycle 33: for MULT, negate the 64-bit product if operand signs differ; for DIV, negate the quotient if signs differ and give the remainder the sign of OpA.
REQ-015 SHALL write HI (product[63:32] or remainder) and LO (product[31:0] or quotient) on the FIX->DONE edge; DONE at cycle 34 with Done=1 for exactly that cycle.
REQ-016 SHALL go DONE->IDLE the following cycle unless Start is asserted, in which case DONE->RUN.
REQ-017 SHALL, for DIV/DIVU with OpB==0, skip RUN/FIX: IDLE->DONE at cycle 1, HI=OpA, LO=32'hFFFFFFFF, DivByZero=1 for the DONE cycle only.
REQ-018 SHALL drive Busy=1 in RUN and FIX, 0 otherwise.
REQ-019 SHALL drive Stall = HiLoRead & Busy (combinational); Stall=0 in IDLE and DONE.
REQ-020 SHALL, on Flush in RUN or FIX, return to IDLE next edge with HI/LO unchanged and no Done pulse; Flush in IDLE/DONE has no effect.
REQ-021 SHALL give Flush priority over Start when both are asserted on the same edge.
REQ-022 SHALL treat MULT of 32'h80000000 by itself as magnitude 2^31 each, product 64'h4000000000000000.

Reset
REQ-023 SHALL on Reset enter IDLE and clear HI, LO, counter, operand registers.
REQ-024 SHALL drive Busy, Done, Stall, DivByZero to 0 during and after reset.
REQ-025 SHALL abandon any in-flight operation on Reset mid-operation with no Done pulse.

Configuration
REQ-026 SHALL, with macro MULDIV_EARLY_OUT_EN defined, leave RUN for FIX after the step that leaves the remaining multiplier magnitude zero (multiply only; divide unchanged).
REQ-027 SHALL, without MULDIV_EARLY_OUT_EN, always take 32 RUN cycles for multiply (Done at cycle 34).

Verification
REQ-028 SHALL test MULTU 32'hFFFFFFFF x 2 -> Done at cycle 34, HI=32'h00000001, LO=32'hFFFFFFFE.
REQ-029 SHALL test DIV -7 / 2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF, DivByZero=0.
REQ-030 SHALL test DIVU 5 / 0 -> Done and DivByZero at cycle 1, HI=5, LO=32'hFFFFFFFF.
REQ-031 SHALL test Flush at cycle 10 of MULT -> IDLE at cycle 11, HI/LO keep prior values, no Done.
REQ-032 SHALL test HiLoRead held during RUN -> Stall=1 through cycle 33, Stall=0 at cycle 34.
REQ-033 SHALL test with MULDIV_EARLY_OUT_EN MULTU 3 x 5 -> FIX at cycle 4, Done at cycle 5, LO=15, HI=0.
